// File: rtl/register_file_sb.sv
// Integer register file with a write-pending scoreboard and busy count.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module register_file_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ISS,
  input  logic [AW-1:0]   ISS_A,
  output logic [AW:0]     NBUSY
);

  localparam logic [AW:0] LIM = NREG[AW:0];

  function automatic logic f_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < LIM);
  endfunction

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_nbusy;

  logic            w_we_ok;
  logic            w_iss_ok;
  logic [NREG-1:0] w_we_dec;
  logic [NREG-1:0] w_iss_dec;
  logic            w_set;
  logic            w_clr;
  logic [AW:0]     w_nbusy_nxt;

  always_comb begin
    w_we_ok   = WE3 && f_ok(A3);
    w_iss_ok  = ISS && f_ok(ISS_A);
    w_we_dec  = '0;
    w_iss_dec = '0;
    for (int i = 1; i < NREG; i++) begin
      w_we_dec[i]  = w_we_ok  && (A3    == AW'(i));
      w_iss_dec[i] = w_iss_ok && (ISS_A == AW'(i));
    end
  end

  // count only real bit transitions; issue wins a same-address write
  always_comb begin
    w_set = w_iss_ok && !(|(w_iss_dec & r_busy));
    w_clr = |(w_we_dec & r_busy & ~w_iss_dec);
    w_nbusy_nxt = r_nbusy
                + (AW+1)'(w_set)
                - (AW+1)'(w_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_nbusy <= '0;
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (w_we_dec[i])
          r_regs[i] <= WD3;
      r_busy  <= (r_busy & ~w_we_dec) | w_iss_dec;
      r_nbusy <= w_nbusy_nxt;
    end
  end

  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_bz1;
  logic            w_bz2;

  always_comb begin
    w_rd1 = '0;
    w_bz1 = 1'b0;
    if (f_ok(A1)) begin
      w_rd1 = r_regs[A1];
      w_bz1 = r_busy[A1];
    end
`ifdef REGFILE_BYPASS_EN
    if (rst_n && w_we_ok && (A3 == A1)) begin
      w_rd1 = WD3;
      w_bz1 = w_iss_ok && (ISS_A == A1);
    end
`endif
  end

  always_comb begin
    w_rd2 = '0;
    w_bz2 = 1'b0;
    if (f_ok(A2)) begin
      w_rd2 = r_regs[A2];
      w_bz2 = r_busy[A2];
    end
`ifdef REGFILE_BYPASS_EN
    if (rst_n && w_we_ok && (A3 == A2)) begin
      w_rd2 = WD3;
      w_bz2 = w_iss_ok && (ISS_A == A2);
    end
`endif
  end

  assign RD1   = w_rd1;
  assign RD2   = w_rd2;
  assign BUSY1 = w_bz1;
  assign BUSY2 = w_bz2;
  assign NBUSY = r_nbusy;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed + randomized bench for register_file_sb against an array model.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  A1, A2, A3, ISS_A;
  logic [31:0] RD1, RD2, WD3;
  logic        BUSY1, BUSY2, WE3, ISS;
  logic [5:0]  NBUSY;

  register_file_sb #(.XLEN(32), .NREG(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .BUSY1(BUSY1), .BUSY2(BUSY2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .ISS(ISS), .ISS_A(ISS_A), .NBUSY(NBUSY)
  );

  logic [4:0]  p_a1, p_a2, p_a3, p_issa;
  logic [15:0] p_rd1, p_rd2, p_wd;
  logic        p_bz1, p_bz2, p_we, p_iss;
  logic [5:0]  p_nbusy;

  register_file_sb #(.XLEN(16), .NREG(24)) u_p (
    .clk(clk), .rst_n(rst_n),
    .A1(p_a1), .A2(p_a2), .RD1(p_rd1), .RD2(p_rd2),
    .BUSY1(p_bz1), .BUSY2(p_bz2),
    .WE3(p_we), .A3(p_a3), .WD3(p_wd),
    .ISS(p_iss), .ISS_A(p_issa), .NBUSY(p_nbusy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] e_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (WE3 && A3 == a) return WD3;
`endif
    return m_reg[a];
  endfunction

  function automatic logic e_bz(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (WE3 && A3 == a) return ISS && ISS_A == a;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [31:0] e_nb();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 32'(c);
  endfunction

  task automatic m_edge();
    if (WE3 && A3 != 0) begin
      m_reg[A3]  = WD3;
      m_busy[A3] = 1'b0;
    end
    if (ISS && ISS_A != 0) m_busy[ISS_A] = 1'b1;
  endtask

  task automatic idle();
    WE3 = 1'b0; ISS = 1'b0;
    p_we = 1'b0; p_iss = 1'b0;
  endtask

  // check model now, take one edge, update model, park at negedge
  task automatic cyc(input string tag);
    #1;
    chk({tag, ".rd1"}, RD1, e_rd(A1));
    chk({tag, ".rd2"}, RD2, e_rd(A2));
    chk({tag, ".bz1"}, 32'(BUSY1), 32'(e_bz(A1)));
    chk({tag, ".bz2"}, 32'(BUSY2), 32'(e_bz(A2)));
    chk({tag, ".nb"}, 32'(NBUSY), e_nb());
    @(posedge clk);
    m_edge();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    A1 = 5; A2 = 6; A3 = 0; ISS_A = 0; WD3 = 0;
    p_a1 = 0; p_a2 = 0; p_a3 = 0; p_issa = 0; p_wd = 0;
    m_clear();
    #2;
    chk("rst.rd1", RD1, 32'h0);
    chk("rst.nb", 32'(NBUSY), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1
    WE3 = 1; A3 = 5; WD3 = 32'hDEADBEEF;
    ISS = 1; ISS_A = 6;
    cyc("t1a");
    #1;
    chk("t1.pre_rd1", RD1, 32'hDEADBEEF);
    chk("t1.pre_bz2", 32'(BUSY2), 32'h1);
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    chk("t1.rd1", RD1, 32'h0);
    chk("t1.bz2", 32'(BUSY2), 32'h0);
    chk("t1.nb", 32'(NBUSY), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2
    A1 = 0; WE3 = 1; A3 = 0; WD3 = 32'hFFFFFFFF;
    ISS = 1; ISS_A = 0;
    cyc("t2a");
    #1;
    chk("t2.rd1", RD1, 32'h0);
    chk("t2.bz1", 32'(BUSY1), 32'h0);
    chk("t2.nb", 32'(NBUSY), 32'h0);

    // T3
    A1 = 3; A2 = 7;
    ISS = 1; ISS_A = 3; cyc("t3a");
    #1; chk("t3.nb1", 32'(NBUSY), 32'd1);
    ISS = 1; ISS_A = 7; cyc("t3b");
    #1; chk("t3.nb2", 32'(NBUSY), 32'd2);
    ISS = 1; ISS_A = 3; cyc("t3c");
    #1; chk("t3.nb3", 32'(NBUSY), 32'd2);
    WE3 = 1; A3 = 7; WD3 = 32'h12345678; cyc("t3d");
    #1;
    chk("t3.nb4", 32'(NBUSY), 32'd1);
    chk("t3.bz7", 32'(BUSY2), 32'h0);
    chk("t3.rd7", RD2, 32'h12345678);

    // T4
    A1 = 9;
    ISS = 1; ISS_A = 9; cyc("t4a");
    #1; chk("t4.nb0", 32'(NBUSY), 32'd2);
    ISS = 1; ISS_A = 9;
    WE3 = 1; A3 = 9; WD3 = 32'hA5A5A5A5;
    cyc("t4b");
    #1;
    chk("t4.rd1", RD1, 32'hA5A5A5A5);
    chk("t4.bz1", 32'(BUSY1), 32'h1);
    chk("t4.nb", 32'(NBUSY), 32'd2);

    // T5
    WE3 = 1; A3 = 4; WD3 = 32'h1; cyc("t5a");
    A1 = 4; WE3 = 1; A3 = 4; WD3 = 32'h0000CAFE;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t5.rd1_same", RD1, 32'h0000CAFE);
`else
    chk("t5.rd1_same", RD1, 32'h1);
`endif
    chk("t5.bz1", 32'(BUSY1), 32'h0);
    cyc("t5b");
    #1;
    chk("t5.rd1_next", RD1, 32'h0000CAFE);

    // T6
    p_we = 1; p_a3 = 30; p_wd = 16'hBEEF;
    p_a1 = 30; p_a2 = 30; p_iss = 1; p_issa = 30;
    #1;
    chk("t6.rd_same", 32'(p_rd1), 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("t6.rd1", 32'(p_rd1), 32'h0);
    chk("t6.bz2", 32'(p_bz2), 32'h0);
    chk("t6.nb", 32'(p_nbusy), 32'h0);
    p_we = 1; p_a3 = 23; p_wd = 16'h5A5A;
    p_iss = 1; p_issa = 22; p_a1 = 23; p_a2 = 22;
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("t6.rd23", 32'(p_rd1), 32'h5A5A);
    chk("t6.bz22", 32'(p_bz2), 32'h1);
    chk("t6.nb1", 32'(p_nbusy), 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      WE3   = ($urandom_range(0, 2) != 0);
      A3    = 5'($urandom_range(0, 31));
      WD3   = $urandom;
      ISS   = ($urandom_range(0, 2) != 0);
      ISS_A = ($urandom_range(0, 5) == 0) ? A3
                                           : 5'($urandom_range(0, 31));
      A1 = ($urandom_range(0, 3) == 0) ? A3
                                        : 5'($urandom_range(0, 31));
      A2 = ($urandom_range(0, 3) == 0) ? ISS_A
                                        : 5'($urandom_range(0, 31));
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
